// File: rtl/m_layer_input_pp.sv
// m_layer_input_pp
// Ping-pong band buffer between a streaming feature-map producer and a
// band-oriented consumer (e.g. a pooling stage). The producer writes elements
// in raster order; every BANK elements form one band that fills one of two
// banks. The consumer reads a completed band at random offsets and then
// releases it, freeing the bank for the producer.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   d_in         write element
//   wr_valid     producer offers d_in
//   wr_ready     buffer can accept d_in (combinational)
//   rd_en        read request
//   rd_addr      element offset within the current read bank
//   rd_release   consumer is done with the current read bank (pulse)
//   frame_clear  synchronous pulse starting a new frame
//   d_out        registered read data (1-cycle latency)
//   band_ready   current read bank holds a complete band (combinational)
//   rd_bank      index of the bank being read
//   band_start   one-cycle pulse after a band completes
//   band_count   bands completed in the current frame
//   frame_done   sticky, the whole frame has been written

module m_layer_input_pp #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAP_W     = 26,
    parameter int unsigned MAP_H     = 26,
    parameter int unsigned BAND_ROWS = 2,
    parameter int unsigned CHANNELS  = 1,
    localparam int unsigned BANK     = BAND_ROWS * MAP_W * CHANNELS,
    localparam int unsigned NBANDS   = MAP_H / BAND_ROWS,
    localparam int unsigned AW       = (BANK > 1) ? $clog2(BANK) : 1,
    localparam int unsigned BCW      = $clog2(NBANDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_release,
    input  logic              frame_clear,
    output logic [DATA_W-1:0] d_out,
    output logic              band_ready,
    output logic              rd_bank,
    output logic              band_start,
    output logic [BCW-1:0]    band_count,
    output logic              frame_done
);

    localparam int unsigned FRAME = MAP_H * MAP_W * CHANNELS;
    localparam int unsigned CW    = $clog2(FRAME + 1);
    localparam int unsigned MW    = $clog2(2 * BANK);

    if (MAP_H % BAND_ROWS != 0) begin : g_bad_geometry
        $error("MAP_H must be a multiple of BAND_ROWS");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [2*BANK];

    logic              wr_bank_q,    wr_bank_d;
    logic [AW-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [CW-1:0]     elem_cnt_q,   elem_cnt_d;
    logic [1:0]        full_q,       full_d;
    logic              rd_bank_q,    rd_bank_d;
    logic [BCW-1:0]    band_count_q, band_count_d;
    logic              frame_done_q, frame_done_d;
    logic              band_start_q, band_start_d;
    logic [DATA_W-1:0] d_out_q;

    // ------------------------------------------------------------------
    // Handshake / request qualification
    // ------------------------------------------------------------------
    logic          wr_ready_w;
    logic          band_ready_w;
    logic          wr_accept;
    logic          wr_last_in_band;
    logic          rd_fire;
    logic          rd_rel_ok;
    logic [MW-1:0] wr_mem_addr;
    logic [MW-1:0] rd_mem_addr;

    assign wr_ready_w   = !full_q[wr_bank_q] && !frame_done_q;
    assign band_ready_w = full_q[rd_bank_q];

    // A write coinciding with frame_clear is dropped so the new frame starts clean.
    assign wr_accept       = wr_valid && wr_ready_w && !frame_clear;
    assign wr_last_in_band = (wr_ptr_q == AW'(BANK - 1));

    assign rd_fire   = rd_en && band_ready_w && (rd_addr < AW'(BANK));
    // frame_clear wins over a same-edge release.
    assign rd_rel_ok = rd_release && band_ready_w && !frame_clear;

    assign wr_mem_addr = wr_bank_q ? (MW'(BANK) + MW'(wr_ptr_q)) : MW'(wr_ptr_q);
    assign rd_mem_addr = rd_bank_q ? (MW'(BANK) + MW'(rd_addr))  : MW'(rd_addr);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        elem_cnt_d   = elem_cnt_q;
        full_d       = full_q;
        rd_bank_d    = rd_bank_q;
        band_count_d = band_count_q;
        frame_done_d = frame_done_q;
        band_start_d = 1'b0;

        if (frame_clear) begin
            wr_bank_d    = 1'b0;
            wr_ptr_d     = '0;
            elem_cnt_d   = '0;
            full_d       = '0;
            rd_bank_d    = 1'b0;
            band_count_d = '0;
            frame_done_d = 1'b0;
        end else begin
            if (wr_accept) begin
                elem_cnt_d = elem_cnt_q + CW'(1);
                if (wr_last_in_band) begin
                    wr_ptr_d          = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    band_count_d      = band_count_q + BCW'(1);
                    band_start_d      = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (elem_cnt_q == CW'(FRAME - 1)) begin
                    frame_done_d = 1'b1;
                end
            end
            // The bank being filled is never full, so it cannot be the bank
            // being released: both updates touch different flags.
            if (rd_rel_ok) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            elem_cnt_q   <= '0;
            full_q       <= '0;
            rd_bank_q    <= 1'b0;
            band_count_q <= '0;
            frame_done_q <= 1'b0;
            band_start_q <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            elem_cnt_q   <= elem_cnt_d;
            full_q       <= full_d;
            rd_bank_q    <= rd_bank_d;
            band_count_q <= band_count_d;
            frame_done_q <= frame_done_d;
            band_start_q <= band_start_d;
        end
    end

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_mem_addr] <= d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_q <= '0;
        end else if (rd_fire) begin
            d_out_q <= mem_q[rd_mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ready   = wr_ready_w;
    assign band_ready = band_ready_w;
    assign rd_bank    = rd_bank_q;
    assign band_start = band_start_q;
    assign band_count = band_count_q;
    assign frame_done = frame_done_q;
    assign d_out      = d_out_q;

endmodule

// File: doc/m_layer_input_pp.md
M_LAYER_INPUT_PP -- requirements
Module: m_layer_input_pp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter MAP_W, default 26, feature-map row length in elements.
REQ-003 SHALL have parameter MAP_H, default 26, feature-map rows per frame; MAP_H SHALL be a multiple of BAND_ROWS.
REQ-004 SHALL have parameter BAND_ROWS, default 2, rows per band (pooling window height).
REQ-005 SHALL have parameter CHANNELS, default 1, channels interleaved per pixel.
REQ-006 SHALL derive BANK = BAND_ROWS*MAP_W*CHANNELS (default 52), FRAME = MAP_H*MAP_W*CHANNELS (default 676), NBANDS = MAP_H/BAND_ROWS (default 13).
REQ-007 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 d_in  input  DATA_W  write element.
REQ-011 wr_valid  input  1  producer offers d_in.
REQ-012 wr_ready  output  1  buffer can accept d_in.
REQ-013 rd_en  input  1  read request.
REQ-014 rd_addr  input  clog2(BANK)  element offset within current read bank.
REQ-015 rd_release  input  1  consumer finished current read bank (pulse).
REQ-016 frame_clear  input  1  synchronous pulse starting a new frame.
REQ-017 d_out  output  DATA_W  registered read data.
REQ-018 band_ready  output  1  current read bank holds a complete band.
REQ-019 rd_bank  output  1  index of bank being read.
REQ-020 band_start  output  1  one-cycle pulse, band completed.
REQ-021 band_count  output  clog2(NBANDS+1)  bands completed in current frame.
REQ-022 frame_done  output  1  sticky, all FRAME elements written.

Function
REQ-023 SHALL contain 2*BANK storage entries as two banks (ping-pong), bank b at addresses b*BANK..b*BANK+BANK-1.
REQ-024 SHALL generate write addresses internally: wr_bank (reset 0), wr_ptr 0..BANK-1 (reset 0), frame element counter 0..FRAME (reset 0).
REQ-025 SHALL hold per-bank flag full[b]; wr_ready = !full[wr_bank] && !frame_done, combinational.
REQ-026 Accept = wr_valid && wr_ready at rising edge: store d_in at wr_bank*BANK+wr_ptr, increment wr_ptr and element counter.
REQ-027 On accept with wr_ptr==BANK-1: set full[wr_bank], wr_ptr to 0, toggle wr_bank, increment band_count.
REQ-028 band_start SHALL be high for exactly the one cycle following the edge that set a full flag.
REQ-029 On accept of element FRAME-1: frame_done to 1 (same edge as the final full flag set); further wr_valid ignored.
REQ-030 band_ready = full[rd_bank], combinational.
REQ-031 rd_en && band_ready && rd_addr<BANK: d_out <= mem[rd_bank*BANK+rd_addr] at that edge (1-cycle latency).
REQ-032 rd_en with !band_ready or rd_addr>=BANK: ignored, d_out holds.
REQ-033 rd_release && band_ready: clear full[rd_bank], toggle rd_bank; rd_release with !band_ready ignored.
REQ-034 Release of one bank and filling of the other on the same edge SHALL both take effect.
REQ-035 Write into a bank whose release occurs on the same edge SHALL NOT occur (wr_ready was low); wr_ready rises the following cycle.
REQ-036 frame_clear SHALL reset wr_bank, wr_ptr, element counter, full flags, rd_bank, band_count, frame_done to 0; memory and d_out untouched; a same-edge write is discarded; frame_clear has priority over rd_release.

Reset
REQ-037 rst high SHALL immediately, without clock, force: wr_ready 1, d_out 0, band_ready 0, rd_bank 0, band_start 0, band_count 0, frame_done 0, all internal pointers and full flags 0.
REQ-038 Memory contents need not be reset; after rst deassertion first accepted write goes to address 0.

Verification (default parameters)
REQ-039 Write 0..51 back-to-back -> band_start pulse cycle after 52nd accept, band_ready 1, band_count 1; rd_addr 0..51 returns 0..51 one cycle later.
REQ-040 Write 104 elements, no release -> wr_ready 0 after 104th accept, 105th held; rd_release -> rd_bank 1, wr_ready 1 next cycle, 105th stored at address 0.
REQ-041 Release bank 0 on same edge as 104th accept -> full[0] 0, full[1] 1, rd_bank 1, band_start pulses, wr_ready 1.
REQ-042 Stream 676 elements with consumer releasing each band -> 13 band_start pulses, band_count 13, frame_done 1, wr_ready 0; frame_clear -> all 0, new frame writes from address 0.
REQ-043 Assert rst between edges after 30 writes -> outputs reach reset values before next edge; after release, band_start occurs only after 52 new accepts.
REQ-044 rd_en with band_ready 0 or rd_addr 60 -> d_out unchanged.
